// File: rtl/b2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), STEP shift-add3 iterations per clock,
// with signed/unsigned operands, saturating overflow and valid/ready handshakes on both sides.
module b2bcd_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 3,
   parameter int STEP  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DIGIT*4-1:0]   out_bcd,
   output logic                 out_neg,
   output logic                 out_ovf
);

   localparam int N  = WIDTH / STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_bin;
   logic [DIGIT*4-1:0]   r_bcd;
   logic                 r_neg;
   logic                 r_ovf;
   logic [CW-1:0]        r_cnt;

   logic [WIDTH-1:0]     w_bin;
   logic [DIGIT*4-1:0]   w_bcd;
   logic                 w_ovf;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)       w_next = CONV;
         CONV:    if (r_cnt == LAST)  w_next = DONE;
         DONE:    if (out_ready)      w_next = IDLE;
         default:                     w_next = IDLE;
      endcase
   end

   // STEP unrolled iterations; a 1 leaving the top digit means the value no longer fits
   always_comb begin
      w_bin = r_bin;
      w_bcd = r_bcd;
      w_ovf = r_ovf;
      for (int s = 0; s < STEP; s++) begin
         for (int d = 0; d < DIGIT; d++) begin
            if (w_bcd[d*4 +: 4] >= 4'd5) w_bcd[d*4 +: 4] = w_bcd[d*4 +: 4] + 4'd3;
         end
         w_ovf = w_ovf | w_bcd[DIGIT*4-1];
         w_bcd = {w_bcd[DIGIT*4-2:0], w_bin[WIDTH-1]};
         w_bin = {w_bin[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin <= '0;
         r_bcd <= '0;
         r_neg <= 1'b0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_bin <= (in_signed && in_data[WIDTH-1]) ? -in_data : in_data;
                  r_neg <= in_signed & in_data[WIDTH-1];
                  r_bcd <= '0;
                  r_ovf <= 1'b0;
                  r_cnt <= '0;
               end
            end
            CONV: begin
               r_bin <= w_bin;
               r_bcd <= w_bcd;
               r_ovf <= w_ovf;
               r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_bcd   = r_ovf ? {DIGIT{4'd9}} : r_bcd;
   assign out_neg   = r_neg;
   assign out_ovf   = r_ovf;

endmodule

// File: doc/b2bcd_seq.md
# b2bcd_seq

- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Processes STEP bits per clock instead of unrolling all WIDTH stages combinationally.
- Adds a per-transaction signed/unsigned mode, overflow detection with saturation, and valid/ready handshakes on input and output.
- Sits between arithmetic datapaths and display/report logic, where area matters more than single-cycle latency.

## Interface
- WIDTH, 8: binary input width. Must be ≥ 2.
- DIGIT, 3: number of BCD output digits. Must be ≥ 1.
- STEP, 1: shift-add3 iterations performed per clock. Must be ≥ 1 and divide WIDTH.
- Derived: N = WIDTH/STEP conversion cycles.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input transaction offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_signed  input  1  1: in_data is two's complement; 0: unsigned.
- in_data  input  WIDTH  binary operand.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_bcd  output  DIGIT*4  BCD magnitude; digit 0 at [3:0].
- out_neg  output  1  result is negative (signed mode only).
- out_ovf  output  1  magnitude exceeded 10^DIGIT-1; out_bcd saturated.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE** (in_ready=1):
  - Accept on in_valid & in_ready.
  - Latch the magnitude into the shift register: if in_signed and in_data[WIDTH-1] = 1, latch -in_data as an unsigned WIDTH-bit value; otherwise latch in_data.
  - -2^(WIDTH-1) gives 2^(WIDTH-1), which fits in WIDTH bits.
  - Latch neg = in_signed & in_data[WIDTH-1].
  - Clear the BCD accumulator, the ovf flag and the counter. Go to CONV.
- **CONV** (in_ready=0, out_valid=0):
  - Each cycle performs STEP iterations, MSB-first.
  - Each iteration: every digit ≥ 5 gets +3 (4-bit, no carry between digits); then shift {bcd, bin} left by 1.
  - Any 1 shifted out of bcd[DIGIT*4-1] sets ovf (sticky).
  - Counter runs 0..N-1. On the cycle counter = N-1, go to DONE.
- **DONE** (out_valid=1):
  - out_bcd = ovf ? all digits 9 : accumulator.
  - out_neg = neg. out_neg = 0 when the result is zero, which only occurs for unsigned or zero input.
  - out_ovf = ovf.
  - Outputs hold stable while out_ready = 0.
  - On out_ready: go to IDLE. out_bcd, out_neg and out_ovf keep their last values, but are qualified only by out_valid.
- in_data and in_signed are sampled only at acceptance. Later changes have no effect.
- in_valid while not in IDLE is ignored; nothing is queued.
- in_ready and out_valid are decoded from state only. They have no combinational path from in_valid or out_ready.

## Timing
- Reset, when rst = 1 at a rising edge:
  - state = IDLE, counter = 0.
  - out_valid = 0, in_ready = 1 in the following cycle.
  - out_bcd = 0, out_neg = 0, out_ovf = 0.
- rst has priority over every handshake. in_valid in the same cycle as rst = 1 is not accepted.
- Reset in CONV or DONE aborts the transaction; no result is produced.
- Latency: if accepted at edge E0, out_valid is high from edge E0+N onward (N cycles later).
- Throughput: one result per N+2 cycles with out_ready held high. The IDLE cycle is mandatory.
- Output handshake completes at the edge where out_valid & out_ready = 1. in_ready is high in the next cycle.

## Test plan
- WIDTH=8, DIGIT=3, STEP=1, unsigned 8'hFF:
  - out_valid exactly 8 cycles after acceptance.
  - out_bcd = 12'h255, out_neg = 0, out_ovf = 0.
  - Also 8'h00 gives 12'h000.
- Signed mode, same instance:
  - 8'h80 gives out_bcd = 12'h128, out_neg = 1.
  - 8'hFF gives 12'h001, out_neg = 1.
  - 8'h7F gives 12'h127, out_neg = 0.
- DIGIT=2 instance, unsigned:
  - 8'd99 gives out_bcd = 8'h99, out_ovf = 0.
  - 8'd100 gives out_bcd = 8'h99, out_ovf = 1.
  - 8'd255 gives 8'h99, out_ovf = 1.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE: out_bcd, out_neg and out_ovf stay stable, in_ready = 0.
  - An in_valid pulse with 8'd7 during this window is ignored.
  - After the output handshake, the next offer of 8'd42 is accepted and gives 12'h042.
- Reset mid-operation:
  - Assert rst for 1 cycle on the 3rd CONV cycle: out_valid never rises for that operand.
  - in_ready = 1 in the cycle after reset, and all outputs are 0.
  - A subsequent unsigned 8'd0 gives 12'h000.
- STEP=2 instance (WIDTH=8, DIGIT=3):
  - unsigned 8'd200 gives out_bcd = 12'h200 with out_valid 4 cycles after acceptance.
  - A random sweep of 1000 operands, both modes, matches the reference model.
